rr_burst_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares one single-ported datapath resource among NUM_PORTS requesters, such as a unified-buffer or weight-FIFO write port.
- A grant is held for a whole multi-beat burst and released on the last-beat handshake, on requester abandonment, or by a hold-limit watchdog.
- Sits between requesting engines (DMA, activation writeback, host interface) and the shared resource's valid/ready port.

---
 rtl/rr_burst_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_burst_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - round-robin arbiter holding one grant per multi-beat burst
// Grant is released on last beat, requester abandonment, or hold-limit watchdog.
module rr_burst_arbiter #(
    parameter  int NUM_PORTS  = 4,
    parameter  int HOLD_LIMIT = 16,
    localparam int IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] last,
    input  logic                 res_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid,
    output logic                 res_valid,
    output logic                 beat_fire,
    output logic                 forced_release
);

    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state, w_nxt_state;
    logic [NUM_PORTS-1:0]   r_grant, w_nxt_grant;
    logic [IDX_W-1:0]       r_grant_idx, w_nxt_idx;
    logic [IDX_W-1:0]       r_ptr, w_nxt_ptr;
    logic [CNT_W-1:0]       r_cnt, w_nxt_cnt;
    logic                   r_forced, w_nxt_forced;

    logic [IDX_W-1:0]       w_after_g;
    logic [IDX_W-1:0]       w_base;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_found;
    logic                   w_release;
    logic                   w_res_valid;
    logic                   w_beat_fire;

    assign w_after_g   = (r_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_grant_idx + IDX_W'(1);
    assign w_res_valid = (r_state == S_BUSY) & req[r_grant_idx];
    assign w_beat_fire = w_res_valid & res_ready;

    // On release the search starts just past g and covers N-1 ports, so g itself is never a candidate.
    assign w_base = (r_state == S_BUSY) ? w_after_g : r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int c;
            c = int'(w_base) + i;
            if (c >= NUM_PORTS) c = c - NUM_PORTS;
            if (!w_found && req[IDX_W'(c)] && ((r_state == S_IDLE) || (i < NUM_PORTS - 1))) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(c);
            end
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_idx    = r_grant_idx;
        w_nxt_ptr    = r_ptr;
        w_nxt_cnt    = r_cnt;
        w_nxt_forced = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt_state = S_BUSY;
                    w_nxt_idx   = w_pick;
                    w_nxt_cnt   = '0;
                end
            end
            S_BUSY: begin
                if (!req[r_grant_idx]) begin
                    w_release = 1'b1;
                end else if (w_beat_fire && last[r_grant_idx]) begin
                    w_release = 1'b1;
                end else if (w_beat_fire && (r_cnt == CNT_W'(HOLD_LIMIT - 1))) begin
                    w_release    = 1'b1;
                    w_nxt_forced = 1'b1;
                end else if (w_beat_fire) begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end

                if (w_release) begin
                    w_nxt_ptr = w_after_g;
                    w_nxt_cnt = '0;
                    if (w_found) begin
                        w_nxt_idx = w_pick;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_idx   = '0;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_idx   = '0;
            end
        endcase

        w_nxt_grant = (w_nxt_state == S_BUSY) ? (NUM_PORTS'(1) << w_nxt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_forced    <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_grant     <= w_nxt_grant;
            r_grant_idx <= w_nxt_idx;
            r_ptr       <= w_nxt_ptr;
            r_cnt       <= w_nxt_cnt;
            r_forced    <= w_nxt_forced;
        end
    end

    assign grant          = r_grant;
    assign grant_idx      = r_grant_idx;
    assign grant_valid    = |r_grant;
    assign res_valid      = w_res_valid;
    assign beat_fire      = w_beat_fire;
    assign forced_release = r_forced;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb/tb_rr_burst_arbiter.sv - scoreboard bench for rr_burst_arbiter
// Driver pushes expected per-cycle outputs from an owner/ptr model; monitor pops and compares.
module tb_rr_burst_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         res_ready;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         res_valid;
    logic         beat_fire;
    logic         forced_release;

    rr_burst_arbiter #(.NUM_PORTS(N), .HOLD_LIMIT(HOLD)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .last           (last),
        .res_ready      (res_ready),
        .grant          (grant),
        .grant_idx      (grant_idx),
        .grant_valid    (grant_valid),
        .res_valid      (res_valid),
        .beat_fire      (beat_fire),
        .forced_release (forced_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   idx;
        logic         gv;
        logic         rv;
        logic         bf;
        logic         fr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner = -1 when idle, beats = beats already moved in this grant.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    bit m_forced = 1'b0;

    function automatic int pick(input int base, input logic [N-1:0] rq, input int excl);
        for (int i = 0; i < N; i++) begin
            int p;
            p = (base + i) % N;
            if (p != excl && rq[p]) return p;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] ls, input bit rdy, input bit rs);
        exp_t e;
        bit   fire;
        bit   rel;
        bit   frc;
        @(negedge clk);
        req       = rq;
        last      = ls;
        res_ready = rdy;
        rst       = rs;

        e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.idx   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.gv    = (m_owner >= 0);
        e.rv    = (m_owner >= 0) && rq[m_owner];
        fire    = e.rv && rdy;
        e.bf    = fire;
        e.fr    = m_forced;
        exp_q.push_back(e);

        if (rs) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_forced = 1'b0;
        end else if (m_owner < 0) begin
            m_forced = 1'b0;
            m_owner  = pick(m_ptr, rq, -1);
            m_beats  = 0;
        end else begin
            rel = 1'b0; frc = 1'b0;
            if (!rq[m_owner]) rel = 1'b1;
            else if (fire && ls[m_owner]) rel = 1'b1;
            else if (fire && (m_beats + 1 == HOLD)) begin rel = 1'b1; frc = 1'b1; end
            else if (fire) m_beats++;
            m_forced = frc;
            if (rel) begin
                int g;
                g       = m_owner;
                m_ptr   = (g + 1) % N;
                m_owner = pick(m_ptr, rq, g);
                m_beats = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] last_at(input int port, input int beat_no);
        return (m_owner == port && m_beats == beat_no - 1) ? N'(1 << port) : '0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",          int'(grant),          int'(e.grant));
                chk("grant_idx",      int'(grant_idx),      int'(e.idx));
                chk("grant_valid",    int'(grant_valid),    int'(e.gv));
                chk("res_valid",      int'(res_valid),      int'(e.rv));
                chk("beat_fire",      int'(beat_fire),      int'(e.bf));
                chk("forced_release", int'(forced_release), int'(e.fr));
                chk("grant_onehot0",  int'($onehot0(grant)), 1);
            end
        end
    end

    initial begin : driver
        logic [N-1:0] rq;
        bit           rdy_pat[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        rst = 1'b1; req = '0; last = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);

        // single port, 3-beat burst
        for (int i = 0; i < 6; i++) cycle(4'b0010, last_at(1, 3), 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // fairness: all ports, 1-beat bursts
        for (int i = 0; i < 12; i++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // backpressure on port 2, last on second fired beat
        for (int i = 0; i < 8; i++) cycle(4'b0100, last_at(2, 2), rdy_pat[i], 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // watchdog: no last ever
        for (int i = 0; i < 14; i++) cycle(4'b1010, 4'b0000, 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // last coincides with the limit beat
        for (int i = 0; i < 8; i++) cycle(4'b0010, last_at(1, HOLD), 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // abandonment by port 0
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        repeat (2) cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
        repeat (3) cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // reset while port 3 holds the grant
        repeat (3) cycle(4'b1000, 4'b0000, 1'b0, 1'b0);
        cycle(4'b1000, 4'b0000, 1'b0, 1'b1);
        repeat (4) cycle(4'b1001, 4'b0000, 1'b1, 1'b0);

        // randomized traffic
        rq = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            cycle(rq, N'($urandom) & N'($urandom), ($urandom_range(3) != 0),
                  ($urandom_range(199) == 0));
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
